accumulate_sequencer: RTL and testbench
=======================================

Name: accumulate_sequencer

Overview:
- Sequential front/back stage wrapped around the team's 8-bit combinational adder with negative/zero/overflow flags.
- Accepts a stream of signed 8-bit operands over a valid/ready handshake.
- Drives the adder's a/b inputs with (accumulator, operand or its two's-complement negation).
- Registers the adder's sum and flags back into the accumulator.
- Produces one final result per run, plus last-step flags and a sticky overflow flag.

Parameters:
- WIDTH, 8, operand/accumulator width; must match the adder width.
- LEN_W, 4, width of the run-length input; maximum run is 2^LEN_W-1 operands.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- length  input  LEN_W  number of operands in the run; sampled with start.
- op_sub  input  1  0 = add, 1 = subtract; sampled with start, fixed for the whole run.
- operand  input  WIDTH  signed operand.
- operand_valid  input  1  operand is presented.
- operand_ready  output  1  block accepts an operand this cycle.
- adder_a  output  WIDTH  to adder input a.
- adder_b  output  WIDTH  to adder input b.
- adder_c  input  WIDTH  sum from adder.
- adder_negative  input  1  adder negative flag.
- adder_zero  input  1  adder zero flag.
- adder_overflow  input  1  adder overflow flag.
- result  output  WIDTH  accumulator value.
- negative  output  1  flag of the last step.
- zero  output  1  flag of the last step.
- overflow  output  1  flag of the last step.
- sticky_ovf  output  1  OR of overflow over the current run.
- busy  output  1  high in ACCUM.
- done  output  1  one-cycle pulse at run end.

Behaviour:
- Only one clock domain; reset is synchronous and active-high. All outputs are registered except operand_ready, adder_a and adder_b, which are combinational from the current state and inputs.
- Reset values: state = IDLE, result = 0, negative = 0, zero = 0, overflow = 0, sticky_ovf = 0, done = 0, busy = 0, operand_ready = 0, remaining count = 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - operand_ready = 0.
  - On start with length != 0: latch length into the remaining count, latch op_sub, clear sticky_ovf and the flags, set the "first" marker, go to ACCUM.
  - On start with length == 0: set result = 0, zero = 1, negative = 0, overflow = 0, go to DONE.
- ACCUM:
  - operand_ready = 1; busy = 1. An operand is accepted in a cycle where operand_valid & operand_ready.
  - First accepted operand loads the accumulator directly, with no add and no negation even when op_sub = 1 (the first operand is the minuend). On that load:
    - negative = operand[7];
    - zero = (operand == 0);
    - overflow = 0.
  - Each later accepted operand performs a step: result <= adder_c, with flags taken from the adder.
  - On every accept, sticky_ovf |= overflow for that step.
  - Every accept decrements the remaining count. When the accept brings the count to 0, go to DONE.
  - A cycle without operand_valid holds all state; there is no timeout.
  - start is ignored in ACCUM.
- Adder drive:
  - adder_a = result.
  - adder_b = operand when adding.
  - adder_b = (~operand + 1) mod 2^WIDTH when subtracting.
- Subtract boundary, operand == 0x80: the negation is again 0x80 and the adder's flag is wrong. The block must override it: overflow = ~result[7] (pre-step accumulator). The sum and the negative/zero flags still come from the adder.
- Latency: a step's result and flags are visible on the cycle after the accept.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - result and the flags hold until the next start is accepted.
  - A start arriving while in DONE is ignored; it is honoured once the block is back in IDLE.
- Arithmetic: all arithmetic wraps modulo 2^WIDTH; there is no saturation.
- Reset mid-run: everything returns to reset values on the next edge, and any operand offered in that cycle is dropped.

Test Plan:
- Add run: length=3, op_sub=0, operands 10, 20, 30 back-to-back. Required: result=60 (0x3C), n=0, z=0, v=0, sticky=0; done pulses one cycle after the 3rd accept; busy for exactly 3 cycles.
- Add overflow: length=2, operands 0x70, 0x20. Required: result=0x90, negative=1, overflow=1, sticky_ovf=1.
- Subtract to zero: length=2, op_sub=1, operands 5, 5. Required: adder_b=0xFB during the 2nd accept; result=0, zero=1, overflow=0.
- Negation boundary, two runs with op_sub=1:
  - 0x00 then 0x80: required result=0x80, overflow=1.
  - 0xFF then 0x80: required result=0x7F, overflow=0.
- Handshake gaps and ignored start: length=2 with operand_valid low for 3 cycles between operands, and start pulsed mid-run. Required: state holds during the gap, the mid-run start has no effect, and done fires once. Then length=0: required done on the following cycle with result=0, zero=1.
- Reset mid-run: length=4, assert rst after 2 accepts. Required: next cycle shows all outputs at reset values and state IDLE; a new run of 1, 2 then produces result=3.

Source files
------------

// File: rtl/accumulate_sequencer.sv
// accumulate_sequencer: sequences a stream of signed operands through an
// external combinational adder. It keeps the running accumulator, the flags
// of the most recent step and an overflow flag that stays set for the whole run.
module accumulate_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        length,
  input  logic                    op_sub,
  input  logic signed [WIDTH-1:0] operand,
  input  logic                    operand_valid,
  output logic                    operand_ready,
  output logic signed [WIDTH-1:0] adder_a,
  output logic signed [WIDTH-1:0] adder_b,
  input  logic signed [WIDTH-1:0] adder_c,
  input  logic                    adder_negative,
  input  logic                    adder_zero,
  input  logic                    adder_overflow,
  output logic signed [WIDTH-1:0] result,
  output logic                    negative,
  output logic                    zero,
  output logic                    overflow,
  output logic                    sticky_ovf,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Most negative value; negating it yields itself, so the adder's overflow
  // flag cannot be trusted for that subtrahend.
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             sub_q;
  logic             first;
  logic             accept;
  logic             step_ovf;

  // Two's-complement negation, wrapping modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Overflow of a non-first step. Subtracting MIN_VAL overflows exactly when
  // the accumulator is non-negative, whatever the adder reports.
  function automatic logic step_overflow(input logic sub, input logic signed [WIDTH-1:0] op,
                                         input logic signed [WIDTH-1:0] acc, input logic add_ovf);
    if (sub && (op == MIN_VAL)) return ~acc[WIDTH-1];
    return add_ovf;
  endfunction

  assign operand_ready = (state == ACCUM);
  assign accept        = operand_valid & operand_ready;
  assign adder_a       = result;
  assign adder_b       = sub_q ? negate(operand) : operand;
  assign step_ovf      = step_overflow(sub_q, operand, result, adder_overflow);

  // Run control, accumulator and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      sub_q      <= 1'b0;
      first      <= 1'b0;
      result     <= '0;
      negative   <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      sticky_ovf <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              remaining  <= length;
              sub_q      <= op_sub;
              sticky_ovf <= 1'b0;
              negative   <= 1'b0;
              zero       <= 1'b0;
              overflow   <= 1'b0;
              first      <= 1'b1;
              busy       <= 1'b1;
              state      <= ACCUM;
            end else begin
              result   <= '0;
              negative <= 1'b0;
              zero     <= 1'b1;
              overflow <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (first) begin
              // The first operand is the minuend/base: loaded, never negated.
              result   <= operand;
              negative <= operand[WIDTH-1];
              zero     <= (operand == '0);
              overflow <= 1'b0;
              first    <= 1'b0;
            end else begin
              result     <= adder_c;
              negative   <= adder_negative;
              zero       <= adder_zero;
              overflow   <= step_ovf;
              sticky_ovf <= sticky_ovf | step_ovf;
            end
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_sequencer.sv
// Bench for accumulate_sequencer: models the adder, drives directed and
// random runs, and compares every cycle against an integer-arithmetic model.
module tb_accumulate_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] length;
  logic       op_sub;
  logic [7:0] operand;
  logic       operand_valid;
  logic       operand_ready;
  logic [7:0] adder_a, adder_b, adder_c;
  logic       adder_negative, adder_zero, adder_overflow;
  logic [7:0] result;
  logic       negative, zero, overflow, sticky_ovf, busy, done;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  accumulate_sequencer #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length), .op_sub(op_sub),
    .operand(operand), .operand_valid(operand_valid), .operand_ready(operand_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_c(adder_c),
    .adder_negative(adder_negative), .adder_zero(adder_zero),
    .adder_overflow(adder_overflow), .result(result), .negative(negative),
    .zero(zero), .overflow(overflow), .sticky_ovf(sticky_ovf), .busy(busy),
    .done(done)
  );

  // The team adder: wrap-around sum with signed flags.
  assign adder_c        = adder_a + adder_b;
  assign adder_negative = adder_c[7];
  assign adder_zero     = (adder_c == 8'h00);
  assign adder_overflow = (adder_a[7] == adder_b[7]) && (adder_c[7] != adder_a[7]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase plus accumulator held as a true signed integer.
  int m_phase;   // 0 idle, 1 running, 2 finishing
  int m_left;
  bit m_first, m_sub;
  int m_acc;
  bit m_n, m_z, m_v, m_sticky;

  always @(posedge clk) begin
    int op, full;
    if (rst) begin
      m_phase = 0; m_left = 0; m_first = 0; m_sub = 0; m_acc = 0;
      m_n = 0; m_z = 0; m_v = 0; m_sticky = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        if (length != 0) begin
          m_left = int'(length); m_sub = op_sub; m_first = 1;
          m_sticky = 0; m_n = 0; m_z = 0; m_v = 0; m_phase = 1;
        end else begin
          m_acc = 0; m_n = 0; m_z = 1; m_v = 0; m_phase = 2;
        end
      end
    end else if (m_phase == 1) begin
      if (operand_valid) begin
        op = int'($signed(operand));
        if (m_first) begin
          m_acc = op; m_v = 0; m_first = 0;
        end else begin
          full  = m_sub ? m_acc - op : m_acc + op;
          m_v   = (full > 127) || (full < -128);
          m_acc = ((full % 256) + 256) % 256;
          if (m_acc > 127) m_acc -= 256;
        end
        m_n = (m_acc < 0);
        m_z = (m_acc == 0);
        m_sticky |= m_v;
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int e;
    logic [31:0] eb;
    if (chk_en) begin
      chk("result", result, m_acc[7:0]);
      chk("negative", negative, m_n);
      chk("zero", zero, m_z);
      chk("overflow", overflow, m_v);
      chk("sticky_ovf", sticky_ovf, m_sticky);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("operand_ready", operand_ready, m_phase == 1);
      if (m_phase == 1) begin
        chk("adder_a", adder_a, m_acc[7:0]);
        e  = m_sub ? -int'($signed(operand)) : int'($signed(operand));
        eb = e;
        chk("adder_b", adder_b, {24'd0, eb[7:0]});
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int len, input bit sub);
    start = 1; length = len[3:0]; op_sub = sub;
    tick();
    start = 0;
  endtask

  task automatic feed(input logic [7:0] op, input int gap);
    operand_valid = 0;
    for (int g = 0; g < gap; g++) tick();
    operand_valid = 1; operand = op;
    tick();
    operand_valid = 0;
  endtask

  initial begin
    rst = 1; start = 0; length = 0; op_sub = 0; operand = 0; operand_valid = 0;
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("reset result", result, 0);
    chk("reset ready", operand_ready, 0);
    chk("reset busy", busy, 0);

    // Add run 10 + 20 + 30.
    busy_cnt = 0; done_cnt = 0;
    start_run(3, 0);
    feed(8'd10, 0); feed(8'd20, 0); feed(8'd30, 0);
    chk("add result", result, 8'h3C);
    chk("add done", done, 1);
    chk("add flags", {negative, zero, overflow, sticky_ovf}, 4'b0000);
    chk("add busy cycles", busy_cnt, 3);
    tick();
    chk("add done one cycle", done, 0);
    chk("add done count", done_cnt, 1);

    // Add overflow 0x70 + 0x20.
    start_run(2, 0);
    feed(8'h70, 0); feed(8'h20, 0);
    chk("ovf result", result, 8'h90);
    chk("ovf n/v/sticky", {negative, overflow, sticky_ovf}, 3'b111);
    chk("model acc", m_acc, -112);
    tick();

    // Subtract to zero 5 - 5.
    start_run(2, 1);
    feed(8'd5, 0);
    operand_valid = 1; operand = 8'd5;
    #2;
    chk("sub adder_b", adder_b, 8'hFB);
    tick();
    operand_valid = 0;
    chk("sub result", result, 8'h00);
    chk("sub zero/ovf", {zero, overflow}, 2'b10);
    tick();

    // Negation boundary.
    start_run(2, 1);
    feed(8'h00, 0); feed(8'h80, 0);
    chk("neg80 a result", result, 8'h80);
    chk("neg80 a ovf", overflow, 1);
    tick();
    start_run(2, 1);
    feed(8'hFF, 0); feed(8'h80, 0);
    chk("neg80 b result", result, 8'h7F);
    chk("neg80 b ovf", overflow, 0);
    tick();

    // Gaps with a start pulsed mid-run.
    done_cnt = 0;
    start_run(2, 0);
    feed(8'd7, 0);
    tick();
    start = 1; length = 4'd5;
    tick();
    start = 0;
    tick();
    feed(8'd9, 0);
    chk("gap result", result, 8'd16);
    tick();
    chk("gap done count", done_cnt, 1);

    // Zero-length run.
    start_run(0, 0);
    chk("len0 done", done, 1);
    chk("len0 result/zero", {result, zero}, 9'h001);
    tick();

    // Reset mid-run; the operand offered with reset is dropped.
    start_run(4, 0);
    feed(8'd1, 0); feed(8'd2, 0);
    rst = 1; operand_valid = 1; operand = 8'd99;
    tick();
    rst = 0; operand_valid = 0;
    chk("rst outputs", {result, negative, zero, overflow, sticky_ovf, busy, done, operand_ready}, 15'h0);
    start_run(2, 0);
    feed(8'd1, 0); feed(8'd2, 0);
    chk("post-rst result", result, 8'd3);
    tick();

    // Random runs, with occasional start pulses while finishing.
    for (int r = 0; r < 40; r++) begin
      int len;
      logic [7:0] op;
      len = $urandom_range(1, 7);
      start_run(len, 1'($urandom_range(0, 1)));
      for (int k = 0; k < len; k++) begin
        case ($urandom_range(0, 5))
          0: op = 8'h80;
          1: op = 8'h7F;
          default: op = 8'($urandom);
        endcase
        feed(op, $urandom_range(0, 2));
      end
      if ($urandom_range(0, 2) == 0) begin
        start = 1; length = 4'd3;
        tick();
        start = 0;
      end else begin
        tick();
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
